// File: rtl/pll_dyn_ctrl.sv
// Dynamic rPLL controller: sequences PLL reset, lock qualification and staggered
// downstream reset release, and retunes the PLL dividers on mode-change requests.
module pll_dyn_ctrl #(
    parameter int                     NUM_MODES    = 2,
    parameter logic [6*NUM_MODES-1:0] FBDSEL_TBL   = {6'd59, 6'd59},
    parameter logic [6*NUM_MODES-1:0] ODSEL_TBL    = {6'd60, 6'd56},
    parameter int                     INIT_MODE    = 0,
    parameter int                     RST_HOLD     = 16,
    parameter int                     LOCK_STABLE  = 256,
    parameter int                     LOCK_TIMEOUT = 65536,
    parameter int                     NUM_DOMAINS  = 3,
    parameter int                     RST_STAGGER  = 4,
    localparam int                    MW           = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic                   clkin,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic [MW-1:0]          req_mode,
    output logic                   req_ready,
    input  logic                   pll_lock,
    output logic                   pll_reset,
    output logic [5:0]             pll_fbdsel,
    output logic [5:0]             pll_odsel,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   locked,
    output logic [MW-1:0]          cur_mode,
    output logic                   err_timeout,
    output logic                   err_mode,
    output logic [7:0]             relock_cnt
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAXC = max2(max2(RST_HOLD, LOCK_STABLE), max2(LOCK_TIMEOUT, RST_STAGGER));
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STAG_LAST = CW'(RST_STAGGER - 1);
    localparam logic [MW:0]   MODES_LIM = (MW + 1)'(NUM_MODES);
    localparam logic [MW-1:0] INIT_M    = MW'(INIT_MODE);

    function automatic logic [5:0] tbl_sel(input logic [6*NUM_MODES-1:0] tbl,
                                           input logic [MW-1:0] m);
        logic [5:0] r;
        r = 6'd0;
        for (int i = 0; i < NUM_MODES; i++) begin
            r = (m == MW'(i)) ? tbl[i*6 +: 6] : r;
        end
        return r;
    endfunction

    localparam logic [5:0] FBD_INIT = tbl_sel(FBDSEL_TBL, INIT_M);
    localparam logic [5:0] ODS_INIT = tbl_sel(ODSEL_TBL, INIT_M);

    typedef enum logic [2:0] {
        S_HOLD    = 3'd0,
        S_WAIT    = 3'd1,
        S_STABLE  = 3'd2,
        S_RELEASE = 3'd3,
        S_RUN     = 3'd4
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic                   pll_reset_q;
    logic [NUM_DOMAINS-1:0] rst_out_q;
    logic                   locked_q;
    logic                   ready_q;
    logic [MW-1:0]          cur_mode_q;
    logic [5:0]             fbd_q;
    logic [5:0]             ods_q;
    logic                   err_to_q;
    logic                   err_mode_q;
    logic [7:0]             relock_q;

    logic [7:0]             relock_d;
    logic                   req_ok_d;
    logic [5:0]             fbd_d;
    logic [5:0]             ods_d;

    // Saturating relock increment, request range check and divider table lookup.
    always_comb begin
        relock_d = (relock_q == 8'hFF) ? relock_q : (relock_q + 8'd1);
        req_ok_d = ({1'b0, req_mode} < MODES_LIM);
        fbd_d    = tbl_sel(FBDSEL_TBL, req_mode);
        ods_d    = tbl_sel(ODSEL_TBL, req_mode);
    end

    // Controller FSM with all outputs registered alongside the state.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q     <= S_HOLD;
            cnt_q       <= '0;
            pll_reset_q <= 1'b1;
            rst_out_q   <= '1;
            locked_q    <= 1'b0;
            ready_q     <= 1'b0;
            cur_mode_q  <= INIT_M;
            fbd_q       <= FBD_INIT;
            ods_q       <= ODS_INIT;
            err_to_q    <= 1'b0;
            err_mode_q  <= 1'b0;
            relock_q    <= 8'd0;
        end else begin
            err_mode_q <= 1'b0;
            case (state_q)
                S_HOLD: begin
                    if (cnt_q >= HOLD_LAST) begin
                        state_q     <= S_WAIT;
                        cnt_q       <= '0;
                        pll_reset_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                S_WAIT: begin
                    // The first lock-high cycle already counts toward stability.
                    if (pll_lock) begin
                        state_q <= S_STABLE;
                        cnt_q   <= ONE;
                    end else if (cnt_q >= TO_LAST) begin
                        err_to_q    <= 1'b1;
                        state_q     <= S_HOLD;
                        cnt_q       <= '0;
                        pll_reset_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                S_STABLE: begin
                    if (!pll_lock) begin
                        state_q <= S_WAIT;
                        cnt_q   <= '0;
                    end else if (cnt_q >= LOCK_LAST) begin
                        state_q   <= S_RELEASE;
                        cnt_q     <= '0;
                        rst_out_q <= rst_out_q << 1;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                S_RELEASE: begin
                    // Left shifts clear one more low-order domain per stagger period.
                    if (!pll_lock) begin
                        state_q     <= S_HOLD;
                        cnt_q       <= '0;
                        pll_reset_q <= 1'b1;
                        rst_out_q   <= '1;
                    end else if (!rst_out_q[NUM_DOMAINS-1]) begin
                        state_q  <= S_RUN;
                        locked_q <= 1'b1;
                        ready_q  <= 1'b1;
                    end else if (cnt_q >= STAG_LAST) begin
                        rst_out_q <= rst_out_q << 1;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                S_RUN: begin
                    if (!pll_lock) begin
                        state_q     <= S_HOLD;
                        cnt_q       <= '0;
                        pll_reset_q <= 1'b1;
                        rst_out_q   <= '1;
                        locked_q    <= 1'b0;
                        ready_q     <= 1'b0;
                        relock_q    <= relock_d;
                    end else if (req_valid && req_ok_d) begin
                        state_q     <= S_HOLD;
                        cnt_q       <= '0;
                        pll_reset_q <= 1'b1;
                        rst_out_q   <= '1;
                        locked_q    <= 1'b0;
                        ready_q     <= 1'b0;
                        cur_mode_q  <= req_mode;
                        fbd_q       <= fbd_d;
                        ods_q       <= ods_d;
                    end else if (req_valid) begin
                        err_mode_q <= 1'b1;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                default: begin
                    state_q     <= S_HOLD;
                    cnt_q       <= '0;
                    pll_reset_q <= 1'b1;
                    rst_out_q   <= '1;
                    locked_q    <= 1'b0;
                    ready_q     <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = ready_q;
    assign pll_reset   = pll_reset_q;
    assign pll_fbdsel  = fbd_q;
    assign pll_odsel   = ods_q;
    assign rst_out     = rst_out_q;
    assign locked      = locked_q;
    assign cur_mode    = cur_mode_q;
    assign err_timeout = err_to_q;
    assign err_mode    = err_mode_q;
    assign relock_cnt  = relock_q;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Self-checking bench for pll_dyn_ctrl: directed bring-up/timeout/glitch/mode scenarios
// followed by randomized stimulus, all compared against a phase/elapsed-time model.
module tb_pll_dyn_ctrl;

    localparam int NM = 3;
    localparam int RH = 4;
    localparam int LS = 8;
    localparam int LT = 32;
    localparam int ND = 2;
    localparam int RS = 2;

    localparam int P_HOLD    = 0;
    localparam int P_WAIT    = 1;
    localparam int P_STABLE  = 2;
    localparam int P_RELEASE = 3;
    localparam int P_RUN     = 4;

    logic          clkin = 1'b0;
    logic          reset;
    logic          req_valid;
    logic [1:0]    req_mode;
    logic          req_ready;
    logic          pll_lock;
    logic          pll_reset;
    logic [5:0]    pll_fbdsel;
    logic [5:0]    pll_odsel;
    logic [ND-1:0] rst_out;
    logic          locked;
    logic [1:0]    cur_mode;
    logic          err_timeout;
    logic          err_mode;
    logic [7:0]    relock_cnt;

    int n_vec = 0;
    int n_err = 0;

    int fbd_tbl [NM] = '{59, 45, 33};
    int ods_tbl [NM] = '{60, 56, 48};

    int m_ph     = P_HOLD;
    int m_el     = 0;
    int m_mode   = 0;
    int m_relock = 0;
    bit m_to     = 1'b0;
    bit m_em     = 1'b0;

    always #5 clkin = ~clkin;

    pll_dyn_ctrl #(
        .NUM_MODES    (NM),
        .FBDSEL_TBL   ({6'd33, 6'd45, 6'd59}),
        .ODSEL_TBL    ({6'd48, 6'd56, 6'd60}),
        .INIT_MODE    (0),
        .RST_HOLD     (RH),
        .LOCK_STABLE  (LS),
        .LOCK_TIMEOUT (LT),
        .NUM_DOMAINS  (ND),
        .RST_STAGGER  (RS)
    ) dut (
        .clkin       (clkin),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_mode    (req_mode),
        .req_ready   (req_ready),
        .pll_lock    (pll_lock),
        .pll_reset   (pll_reset),
        .pll_fbdsel  (pll_fbdsel),
        .pll_odsel   (pll_odsel),
        .rst_out     (rst_out),
        .locked      (locked),
        .cur_mode    (cur_mode),
        .err_timeout (err_timeout),
        .err_mode    (err_mode),
        .relock_cnt  (relock_cnt)
    );

    // Domains released so far in the release phase: first one at entry, then one per stagger period.
    function automatic int released_n();
        int r;
        r = 1 + m_el / RS;
        return (r > ND) ? ND : r;
    endfunction

    function automatic int exp_rst();
        int all_ones;
        all_ones = (1 << ND) - 1;
        if (m_ph == P_RUN) return 0;
        if (m_ph == P_RELEASE) return all_ones & ~((1 << released_n()) - 1);
        return all_ones;
    endfunction

    task automatic go_hold();
        m_ph = P_HOLD;
        m_el = 0;
    endtask

    task automatic model_step();
        if (reset) begin
            go_hold();
            m_mode   = 0;
            m_relock = 0;
            m_to     = 1'b0;
            m_em     = 1'b0;
        end else begin
            m_em = 1'b0;
            case (m_ph)
                P_HOLD: begin
                    if (m_el + 1 == RH) begin m_ph = P_WAIT; m_el = 0; end
                    else m_el++;
                end
                P_WAIT: begin
                    if (pll_lock) begin m_ph = P_STABLE; m_el = 1; end
                    else if (m_el + 1 == LT) begin m_to = 1'b1; go_hold(); end
                    else m_el++;
                end
                P_STABLE: begin
                    if (!pll_lock) begin m_ph = P_WAIT; m_el = 0; end
                    else if (m_el + 1 == LS) begin m_ph = P_RELEASE; m_el = 0; end
                    else m_el++;
                end
                P_RELEASE: begin
                    if (!pll_lock) go_hold();
                    else if (released_n() == ND) m_ph = P_RUN;
                    else m_el++;
                end
                P_RUN: begin
                    if (!pll_lock) begin
                        if (m_relock < 255) m_relock++;
                        go_hold();
                    end else if (req_valid && int'(req_mode) < NM) begin
                        m_mode = int'(req_mode);
                        go_hold();
                    end else if (req_valid) begin
                        m_em = 1'b1;
                    end
                end
                default: go_hold();
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pll_reset",   32'(pll_reset),   32'(m_ph == P_HOLD));
        chk("rst_out",     32'(rst_out),     32'(exp_rst()));
        chk("locked",      32'(locked),      32'(m_ph == P_RUN));
        chk("req_ready",   32'(req_ready),   32'(m_ph == P_RUN));
        chk("cur_mode",    32'(cur_mode),    32'(m_mode));
        chk("pll_fbdsel",  32'(pll_fbdsel),  32'(fbd_tbl[m_mode]));
        chk("pll_odsel",   32'(pll_odsel),   32'(ods_tbl[m_mode]));
        chk("err_timeout", 32'(err_timeout), 32'(m_to));
        chk("err_mode",    32'(err_mode),    32'(m_em));
        chk("relock_cnt",  32'(relock_cnt),  32'(m_relock));
    endtask

    task automatic step();
        @(posedge clkin);
        model_step();
        #1;
        check_all();
    endtask

    task automatic wait_locked(input int budget);
        int n;
        n = 0;
        while (locked !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("wait_locked", 32'(locked), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        pll_lock  = 1'b0;
        req_valid = 1'b0;
        req_mode  = 2'd0;
        step();
        step();
        chk("reset_rst_out", 32'(rst_out), 32'd3);
        chk("reset_odsel", 32'(pll_odsel), 32'd60);

        // Bring-up: lock arrives 10 cycles after reset release.
        reset = 1'b0;
        repeat (3) step();
        chk("bring_preset_hi", 32'(pll_reset), 32'd1);
        step();
        chk("bring_preset_lo", 32'(pll_reset), 32'd0);
        repeat (6) step();
        pll_lock = 1'b1;
        repeat (7) step();
        chk("bring_rst_11", 32'(rst_out), 32'd3);
        step();
        chk("bring_rst_10", 32'(rst_out), 32'd2);
        repeat (2) step();
        chk("bring_rst_00", 32'(rst_out), 32'd0);
        step();
        chk("bring_locked", 32'(locked), 32'd1);

        // Mode switch to mode 1.
        req_valid = 1'b1;
        req_mode  = 2'd1;
        step();
        req_valid = 1'b0;
        chk("sw_odsel", 32'(pll_odsel), 32'd56);
        chk("sw_cur_mode", 32'(cur_mode), 32'd1);
        chk("sw_rst_out", 32'(rst_out), 32'd3);
        chk("sw_locked", 32'(locked), 32'd0);
        wait_locked(60);

        // Lock loss with a simultaneous valid request: loss wins.
        pll_lock  = 1'b0;
        req_valid = 1'b1;
        req_mode  = 2'd2;
        step();
        req_valid = 1'b0;
        chk("loss_relock", 32'(relock_cnt), 32'd1);
        chk("loss_cur_mode", 32'(cur_mode), 32'd1);
        chk("loss_rst_out", 32'(rst_out), 32'd3);
        pll_lock = 1'b1;
        wait_locked(60);
        for (int i = 0; i < 299; i++) begin
            pll_lock = 1'b0;
            step();
            pll_lock = 1'b1;
            wait_locked(60);
        end
        chk("relock_sat", 32'(relock_cnt), 32'd255);

        // Out-of-range request.
        req_valid = 1'b1;
        req_mode  = 2'd3;
        step();
        req_valid = 1'b0;
        chk("oor_err_mode", 32'(err_mode), 32'd1);
        chk("oor_locked", 32'(locked), 32'd1);
        chk("oor_odsel", 32'(pll_odsel), 32'd56);
        chk("oor_fbdsel", 32'(pll_fbdsel), 32'd45);
        step();
        chk("oor_pulse_end", 32'(err_mode), 32'd0);

        // Glitch at stable count 5.
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (9) step();
        pll_lock = 1'b0;
        step();
        chk("glitch_rst", 32'(rst_out), 32'd3);
        pll_lock = 1'b1;
        repeat (7) step();
        chk("glitch_rst_held", 32'(rst_out), 32'd3);
        step();
        chk("glitch_rst_rel", 32'(rst_out), 32'd2);

        // Lock timeout.
        reset = 1'b1;
        step();
        reset    = 1'b0;
        pll_lock = 1'b0;
        repeat (35) step();
        chk("to_not_yet", 32'(err_timeout), 32'd0);
        step();
        chk("to_set", 32'(err_timeout), 32'd1);
        chk("to_preset", 32'(pll_reset), 32'd1);
        repeat (3) step();
        chk("to_preset_held", 32'(pll_reset), 32'd1);
        step();
        chk("to_preset_end", 32'(pll_reset), 32'd0);
        chk("to_sticky", 32'(err_timeout), 32'd1);
        reset = 1'b1;
        step();
        chk("to_cleared", 32'(err_timeout), 32'd0);
        reset = 1'b0;

        // Randomized traffic including occasional mid-operation resets.
        repeat (2500) begin
            pll_lock  = ($urandom_range(0, 99) < 96);
            req_valid = ($urandom_range(0, 7) == 0);
            req_mode  = 2'($urandom_range(0, 3));
            reset     = ($urandom_range(0, 399) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pll_dyn_ctrl.md
PLL_DYN_CTRL -- requirements
Module: pll_dyn_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter NUM_MODES, default 2, number of selectable frequency modes (1..16).
REQ-003 Parameter FBDSEL_TBL, default {6'd59,6'd59}, packed 6-bit FBDSEL code per mode, mode 0 in LSBs.
REQ-004 Parameter ODSEL_TBL, default {6'd60,6'd56}, packed 6-bit ODSEL code per mode, mode 0 in LSBs.
REQ-005 Parameter INIT_MODE, default 0, mode applied after reset.
REQ-006 Parameter RST_HOLD, default 16, cycles pll_reset is held high.
REQ-007 Parameter LOCK_STABLE, default 256, consecutive pll_lock-high cycles required.
REQ-008 Parameter LOCK_TIMEOUT, default 65536, maximum cycles waiting for the first pll_lock.
REQ-009 Parameter NUM_DOMAINS, default 3, downstream reset channels.
REQ-010 Parameter RST_STAGGER, default 4, cycles between successive domain releases.
REQ-011 Localparam MW = max(1, clog2(NUM_MODES)).
REQ-012 Ports:
- clkin  in  1  27 MHz reference clock; all logic runs on it
- reset  in  1  synchronous active-high reset
- req_valid  in  1  mode-change request
- req_mode  in  MW  requested mode
- req_ready  out  1  request accepted when valid&&ready
- pll_lock  in  1  raw rPLL LOCK (already synchronised)
- pll_reset  out  1  rPLL RESET
- pll_fbdsel  out  6  rPLL FBDSEL (dynamic)
- pll_odsel  out  6  rPLL ODSEL (dynamic)
- rst_out  out  NUM_DOMAINS  active-high per-domain resets
- locked  out  1  qualified lock, all domains released
- cur_mode  out  MW  mode currently applied
- err_timeout  out  1  sticky lock-timeout flag
- err_mode  out  1  one-cycle pulse on out-of-range request
- relock_cnt  out  8  saturating count of lock losses in RUN

Function
REQ-013 All outputs SHALL be registered.
REQ-014 States SHALL be HOLD, WAIT, STABLE, RELEASE and RUN.
REQ-015 HOLD: pll_reset=1 for exactly RST_HOLD cycles, then WAIT.
REQ-016 WAIT: pll_reset=0; pll_lock high -> STABLE; LOCK_TIMEOUT cycles without lock -> set err_timeout, go to HOLD.
REQ-017 STABLE: a counter SHALL count consecutive pll_lock-high cycles; on reaching LOCK_STABLE -> RELEASE; pll_lock low -> clear the counter and go to WAIT.
REQ-018 RELEASE: rst_out[0] SHALL deassert on entry, and each subsequent bit SHALL deassert RST_STAGGER cycles after the previous one; after the last bit -> RUN.
REQ-019 RELEASE: pll_lock low SHALL reassert all rst_out and go to HOLD.
REQ-020 RUN: locked=1 and req_ready=1; in all other states both SHALL be 0.
REQ-021 RUN with pll_lock low: the next cycle SHALL set rst_out all-ones and locked=0, increment relock_cnt (saturating at 255), and go to HOLD.
REQ-022 RUN with req_valid && req_mode<NUM_MODES: cur_mode, pll_fbdsel and pll_odsel SHALL update from the tables in the next cycle, alongside rst_out all-ones, locked=0 and entry to HOLD.
REQ-023 RUN with req_valid && req_mode>=NUM_MODES: the request SHALL be accepted, err_mode pulsed for one cycle, and state and outputs otherwise unchanged.
REQ-024 Lock loss SHALL take priority over a request in the same cycle; the request is dropped and pll_lock loss handling applies.
REQ-025 pll_fbdsel and pll_odsel SHALL change only on entry to HOLD.
REQ-026 err_timeout SHALL clear only on reset.

Reset
REQ-027 Reset SHALL force: state HOLD with counter cleared, pll_reset=1, rst_out all-ones, locked=0, req_ready=0, cur_mode=INIT_MODE, dividers from the INIT_MODE table entry, err_timeout=0, err_mode=0, relock_cnt=0.
REQ-028 Reset asserted mid-operation, in any state, SHALL restart the HOLD sequence on the following cycle.

Verification
Bench parameters: RST_HOLD=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, NUM_DOMAINS=2, RST_STAGGER=2.
REQ-029 Bring-up: release reset, raise pll_lock 10 cycles later -> pll_reset high 4 cycles, rst_out 2'b11->2'b10 after 8 lock cycles, ->2'b00 two cycles later, then locked=1.
REQ-030 Timeout: pll_lock held low -> err_timeout=1 after 32 WAIT cycles, pll_reset pulses again for 4 cycles.
REQ-031 Glitch: drop pll_lock at STABLE count 5 -> returns to WAIT, needs 8 fresh lock cycles, rst_out stays 2'b11.
REQ-032 Mode switch: in RUN, req_mode=1 -> next cycle pll_odsel=6'd56, cur_mode=1, rst_out=2'b11, full relock sequence follows.
REQ-033 Lock loss in RUN with a simultaneous valid request -> relock_cnt +1, cur_mode unchanged; 300 losses -> relock_cnt=255.
REQ-034 Out-of-range: NUM_MODES=3, req_mode=3 -> err_mode pulse, locked stays 1, dividers unchanged.
